pic24_icsp_engine: RTL and testbench
====================================

Name: pic24_icsp_engine

Overview:
- Parametrised ICSP serial engine; successor to the fixed-function pic24programmer shifter.
- Accepts queued commands over a valid/ready interface and produces PIC24 ICSP waveforms on PGCx/PGDx/MCLRn.
- Command set: ENTER (MCLR + key), SIX (execute instruction), REGOUT (read VISI), EXIT.
- Sits between a programming-sequencer FSM (or host bridge) and the device pins; read data returns on a one-cycle response strobe.

Parameters:
- CLK_DIV, 4, clk50MHz cycles per PGC half-period (≥1); bit period = 2*CLK_DIV cycles.
- SIX_W, 24, SIX payload bits.
- READ_W, 16, REGOUT read bits.
- IDLE_CLKS, 8, REGOUT turnaround PGC pulses.
- KEY_W, 32, ENTER key bits.
- MCLR_WAIT, 500, clk cycles MCLRn held low before the key, and low after the key before release.

Ports:
- clk50MHz  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  engine idle; accepts the command this cycle.
- cmd_op  in  2  0=SIX, 1=REGOUT, 2=ENTER, 3=EXIT.
- cmd_data  in  32  SIX: [SIX_W-1:0] payload; ENTER: [KEY_W-1:0] key; otherwise ignored.
- rsp_valid  out  1  one-cycle pulse: REGOUT data ready.
- rsp_data  out  READ_W  last read word; held until the next REGOUT completes.
- busy  out  1  high from accept until return to IDLE.
- PGCx  out  1  ICSP clock.
- PGDx_in  in  1  ICSP data from device.
- PGDx_out  out  1  ICSP data to device.
- PGDx_dir  out  1  1 = engine drives PGD, 0 = input.
- MCLRn  out  1  target reset.

Behaviour:
- Clock and reset: one clock, clk50MHz. Reset is asynchronous, active-low, on rstn.
- Reset values: PGCx=0, PGDx_out=0, PGDx_dir=1, MCLRn=0, cmd_ready=0 during reset, busy=0, rsp_valid=0, rsp_data=0, state=IDLE.
- Handshake:
  - cmd_ready = (state==IDLE).
  - Accept on cmd_valid&&cmd_ready; cmd_op/cmd_data are latched at accept.
  - busy rises the next cycle.
  - cmd_valid while not ready is ignored, not queued.
- Bit cell, CLK_DIV-cycle half periods:
  - Phase H: PGCx=1, PGDx_out updated at its first cycle.
  - Phase L: PGCx=0; the device latches on the PGC falling edge.
  - Reads: PGDx_in is sampled on the last clk of phase H, immediately before the falling edge.
- SIX:
  - 4 command bits 0000, then SIX_W payload bits, LSB first. PGDx_dir=1 throughout.
  - Total (4+SIX_W)*2*CLK_DIV cycles.
  - Return to IDLE with PGCx=0, PGDx_out=0.
- REGOUT:
  - 4 command bits 0001, LSB first, so the first bit is 1.
  - PGDx_dir drops to 0 at the start of the first idle pulse.
  - IDLE_CLKS pulses with no sampling.
  - READ_W pulses sampled LSB first into a shift register.
  - rsp_data updates and rsp_valid pulses on the cycle after the last sample. The same cycle, PGDx_dir returns to 1 and the FSM returns to IDLE.
- ENTER:
  - MCLRn=0 for MCLR_WAIT cycles.
  - Shift KEY_W bits MSB first, PGC pulsing as above.
  - PGDx_out=0, PGCx=0 for MCLR_WAIT cycles.
  - MCLRn=1, then IDLE.
  - ENTER issued while MCLRn=1 drives MCLRn low first (restart entry).
- EXIT: PGCx=0, PGDx_out=0, MCLRn=0, PGDx_dir=1 for one cycle, then IDLE. MCLRn stays 0 until the next ENTER.
- FSM states: IDLE, MCLR_LO, SHIFT_OUT, TURN, SHIFT_IN, MCLR_POST, DONE.
  - SHIFT_OUT bit counter width = clog2(max(KEY_W, 4+SIX_W)+1).
  - Half-period counter width = clog2(CLK_DIV+1).
  - SIX: SHIFT_OUT→DONE.
  - REGOUT: SHIFT_OUT→TURN→SHIFT_IN→DONE.
  - ENTER: MCLR_LO→SHIFT_OUT→MCLR_POST→DONE.
  - DONE→IDLE in one cycle; cmd_ready reasserts the cycle after DONE.
- Back-to-back: minimum one IDLE cycle between commands; PGCx is low during it.
- CLK_DIV=1: PGC toggles every cycle; sampling uses the single H cycle.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous). Any partial read is discarded and rsp_valid does not pulse.

Decomposition:
- Package pic24_icsp_pkg:
  - op codes OP_SIX/OP_REGOUT/OP_ENTER/OP_EXIT.
  - ICSP 4-bit command constants CMD_SIX=4'b0000, CMD_REGOUT=4'b0001.
  - default key constant ICSP_KEY=32'h4D434851.
  - state enum.
- Sub-module pic24_icsp_bitclk: half-period counter that generates PGCx, the phase-H-start "drive" strobe and the end-of-H "sample" strobe.

Test Plan:
- Reset, then ENTER with cmd_data=32'h4D434851, CLK_DIV=2, MCLR_WAIT=10 -> MCLRn low 10 cycles; 32 PGC pulses with PGDx_out sequence 0100_1101… MSB first; MCLRn=1 after 10 more low cycles; cmd_ready returns.
- SIX with cmd_data=24'h040200, CLK_DIV=2 -> exactly 28 PGC rising edges; bits sampled at PGC falling edges = 0000 then 0x040200 LSB first; busy lasts 112 cycles plus DONE.
- REGOUT with device model driving 16'hA55A LSB first after 8 idle clocks -> PGDx_dir 1 for 4 pulses, 0 for 24; rsp_data=16'hA55A; rsp_valid high exactly 1 cycle.
- SIX immediately followed by REGOUT, cmd_valid held high -> second command accepted the cycle cmd_ready rises; no PGC glitch in between.
- cmd_valid pulsed while busy -> ignored: no extra PGC pulses and the command is not executed later.
- Assert rstn=0 mid-REGOUT at bit 10 -> PGCx=0, MCLRn=0, PGDx_dir=1 immediately; no rsp_valid; after release the engine accepts a new SIX normally.

Source files
------------

// File: rtl/pic24_icsp_pkg.sv
// Shared constants for the PIC24 ICSP engine: host op codes, ICSP command
// nibbles, the default entry key and the sequencer state encoding.
package pic24_icsp_pkg;

  localparam logic [1:0] OP_SIX    = 2'd0;
  localparam logic [1:0] OP_REGOUT = 2'd1;
  localparam logic [1:0] OP_ENTER  = 2'd2;
  localparam logic [1:0] OP_EXIT   = 2'd3;

  localparam logic [3:0]  CMD_SIX    = 4'b0000;
  localparam logic [3:0]  CMD_REGOUT = 4'b0001;
  localparam logic [31:0] ICSP_KEY   = 32'h4D434851;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_MCLR_LO   = 3'd1;
  localparam state_t ST_SHIFT_OUT = 3'd2;
  localparam state_t ST_TURN      = 3'd3;
  localparam state_t ST_SHIFT_IN  = 3'd4;
  localparam state_t ST_MCLR_POST = 3'd5;
  localparam state_t ST_DONE      = 3'd6;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pic24_icsp_bitclk.sv
// PGC bit-cell generator: CLK_DIV cycles high (phase H) then CLK_DIV cycles low
// (phase L) while enabled, with strobes marking H start, H end and cell end.
module pic24_icsp_bitclk #(
  parameter int CLK_DIV = 4
) (
  input  logic clk50MHz,
  input  logic rstn,
  input  logic en,
  output logic pgc,
  output logic drive,
  output logic sample,
  output logic bit_end
);

  localparam int HW = $clog2(CLK_DIV + 1);
  localparam logic [HW-1:0] LAST = HW'(CLK_DIV - 1);

  logic [HW-1:0] cnt_q, cnt_d;
  logic          low_q, low_d;

  // Disabling always rewinds to the first cycle of phase H so every command
  // starts with a clean rising edge.
  always_comb begin
    cnt_d = cnt_q;
    low_d = low_q;
    if (!en) begin
      cnt_d = '0;
      low_d = 1'b0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
      low_d = ~low_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk50MHz or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
      low_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      low_q <= low_d;
    end
  end

  assign pgc     = en & ~low_q;
  assign drive   = pgc & (cnt_q == '0);
  assign sample  = pgc & (cnt_q == LAST);
  assign bit_end = en & low_q & (cnt_q == LAST);

endmodule

// File: rtl/pic24_icsp_engine.sv
// PIC24 ICSP serial engine: executes ENTER / SIX / REGOUT / EXIT commands from
// a valid/ready queue and drives PGC, PGD and MCLR to the target.
module pic24_icsp_engine
  import pic24_icsp_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int SIX_W     = 24,
  parameter int READ_W    = 16,
  parameter int IDLE_CLKS = 8,
  parameter int KEY_W     = 32,
  parameter int MCLR_WAIT = 500
) (
  input  logic              clk50MHz,
  input  logic              rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [31:0]       cmd_data,
  output logic              rsp_valid,
  output logic [READ_W-1:0] rsp_data,
  output logic              busy,
  output logic              PGCx,
  input  logic              PGDx_in,
  output logic              PGDx_out,
  output logic              PGDx_dir,
  output logic              MCLRn
);

  localparam int OUT_W = max2(KEY_W, 4 + SIX_W);
  localparam int BC_W  = $clog2(max2(max2(OUT_W, IDLE_CLKS), READ_W) + 1);
  localparam int WC_W  = $clog2(MCLR_WAIT + 1);

  localparam logic [BC_W-1:0] NB_SIX    = BC_W'(4 + SIX_W);
  localparam logic [BC_W-1:0] NB_REGOUT = BC_W'(4);
  localparam logic [BC_W-1:0] NB_KEY    = BC_W'(KEY_W);
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(MCLR_WAIT - 1);

  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [OUT_W-1:0]  sh_q, sh_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WC_W-1:0]   wait_q, wait_d;
  logic [READ_W-1:0] rd_q, rd_d;
  logic [READ_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              mclrn_q, mclrn_d;

  logic              clk_en, pgc, drive, sample, bit_end;
  logic              accept;
  logic [BC_W-1:0]   nbits;

  assign clk_en = (state_q == ST_SHIFT_OUT) || (state_q == ST_TURN) ||
                  (state_q == ST_SHIFT_IN);

  pic24_icsp_bitclk #(.CLK_DIV(CLK_DIV)) u_bitclk (
    .clk50MHz (clk50MHz),
    .rstn     (rstn),
    .en       (clk_en),
    .pgc      (pgc),
    .drive    (drive),
    .sample   (sample),
    .bit_end  (bit_end)
  );

  assign cmd_ready = (state_q == ST_IDLE) && rstn;
  assign accept    = cmd_valid && cmd_ready;
  assign nbits     = (op_q == OP_ENTER)  ? NB_KEY :
                     (op_q == OP_REGOUT) ? NB_REGOUT : NB_SIX;

  // bit_cnt counts pulses started (drive strobes) in the current state, so it
  // already equals the total on the final pulse of each phase.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    sh_d        = sh_q;
    bit_cnt_d   = bit_cnt_q;
    wait_d      = wait_q;
    rd_d        = rd_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    mclrn_d     = mclrn_q;
    if (drive) begin
      bit_cnt_d = bit_cnt_q + 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d      = cmd_op;
          bit_cnt_d = '0;
          wait_d    = '0;
          case (cmd_op)
            OP_SIX: begin
              sh_d    = OUT_W'({cmd_data[SIX_W-1:0], CMD_SIX});
              state_d = ST_SHIFT_OUT;
            end
            OP_REGOUT: begin
              sh_d    = OUT_W'(CMD_REGOUT);
              state_d = ST_SHIFT_OUT;
            end
            OP_ENTER: begin
              sh_d    = OUT_W'(cmd_data[KEY_W-1:0]);
              mclrn_d = 1'b0;
              state_d = ST_MCLR_LO;
            end
            default: begin
              mclrn_d = 1'b0;
              state_d = ST_DONE;
            end
          endcase
        end
      end
      ST_MCLR_LO: begin
        wait_d = wait_q + 1'b1;
        if (wait_q == WAIT_LAST) begin
          wait_d  = '0;
          state_d = ST_SHIFT_OUT;
        end
      end
      ST_SHIFT_OUT: begin
        if (bit_end) begin
          sh_d = (op_q == OP_ENTER) ? (sh_q << 1) : (sh_q >> 1);
          if (bit_cnt_q == nbits) begin
            bit_cnt_d = '0;
            if (op_q == OP_REGOUT)     state_d = ST_TURN;
            else if (op_q == OP_ENTER) state_d = ST_MCLR_POST;
            else                       state_d = ST_DONE;
          end
        end
      end
      ST_TURN: begin
        if (bit_end && (bit_cnt_q == BC_W'(IDLE_CLKS))) begin
          bit_cnt_d = '0;
          state_d   = ST_SHIFT_IN;
        end
      end
      ST_SHIFT_IN: begin
        if (sample) begin
          rd_d = {PGDx_in, rd_q[READ_W-1:1]};
          if (bit_cnt_d == BC_W'(READ_W)) begin
            rsp_data_d  = rd_d;
            rsp_valid_d = 1'b1;
            state_d     = ST_DONE;
          end
        end
      end
      ST_MCLR_POST: begin
        wait_d = wait_q + 1'b1;
        if (wait_q == WAIT_LAST) begin
          wait_d  = '0;
          mclrn_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk50MHz or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_SIX;
      sh_q        <= '0;
      bit_cnt_q   <= '0;
      wait_q      <= '0;
      rd_q        <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      mclrn_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      sh_q        <= sh_d;
      bit_cnt_q   <= bit_cnt_d;
      wait_q      <= wait_d;
      rd_q        <= rd_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      mclrn_q     <= mclrn_d;
    end
  end

  // Pin outputs decode straight from registered state so an asynchronous
  // reset forces them to their idle levels without waiting for a clock.
  assign PGCx      = pgc;
  assign PGDx_out  = (state_q == ST_SHIFT_OUT) &&
                     ((op_q == OP_ENTER) ? sh_q[KEY_W-1] : sh_q[0]);
  assign PGDx_dir  = !((state_q == ST_TURN) || (state_q == ST_SHIFT_IN));
  assign MCLRn     = mclrn_q;
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_pic24_icsp_engine.sv
// Randomised bench for pic24_icsp_engine: observes pin activity per command and
// compares it against bit streams and timings derived from the ICSP rules.
module tb_pic24_icsp_engine;
  import pic24_icsp_pkg::*;

  localparam int CLK_DIV   = 2;
  localparam int SIX_W     = 24;
  localparam int READ_W    = 16;
  localparam int IDLE_CLKS = 8;
  localparam int KEY_W     = 32;
  localparam int MCLR_WAIT = 10;

  logic              clk50MHz = 1'b0;
  logic              rstn;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [31:0]       cmd_data;
  logic              rsp_valid;
  logic [READ_W-1:0] rsp_data;
  logic              busy;
  logic              PGCx;
  logic              PGDx_in;
  logic              PGDx_out;
  logic              PGDx_dir;
  logic              MCLRn;

  pic24_icsp_engine #(
    .CLK_DIV(CLK_DIV), .SIX_W(SIX_W), .READ_W(READ_W),
    .IDLE_CLKS(IDLE_CLKS), .KEY_W(KEY_W), .MCLR_WAIT(MCLR_WAIT)
  ) dut (
    .clk50MHz (clk50MHz),
    .rstn     (rstn),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_data (cmd_data),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .busy     (busy),
    .PGCx     (PGCx),
    .PGDx_in  (PGDx_in),
    .PGDx_out (PGDx_out),
    .PGDx_dir (PGDx_dir),
    .MCLRn    (MCLRn)
  );

  always #10 clk50MHz = ~clk50MHz;

  int n_vec = 0;
  int n_err = 0;

  // Observation of one command
  int          rises, rises_in, nfall, busy_cyc, pre_lo, post_lo, rsp_cnt;
  logic [63:0] obs_bits;
  logic [15:0] rsp_word;
  logic        seen_rise, prev_pgc, prev_out, prev_dir;

  // Reference state
  logic [READ_W-1:0] dev_word;
  logic [READ_W-1:0] model_rsp;
  logic              model_mclrn;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    rises = 0; rises_in = 0; nfall = 0; busy_cyc = 0; pre_lo = 0; post_lo = 0;
    rsp_cnt = 0; obs_bits = '0; rsp_word = '0; seen_rise = 1'b0;
    prev_pgc = PGCx; prev_out = PGDx_out; prev_dir = PGDx_dir;
  endtask

  // Called once per falling clk edge; also plays the target device on PGD.
  task automatic observe();
    int k;
    if (PGCx && !prev_pgc) begin
      rises++;
      seen_rise = 1'b1;
      post_lo = 0;
      if (!PGDx_dir) begin
        rises_in++;
        k = rises_in - 1 - IDLE_CLKS;
        PGDx_in = (k >= 0 && k < READ_W) ? dev_word[k] : 1'b0;
      end
    end
    if (!PGCx && prev_pgc && prev_dir) begin
      if (nfall < 64) obs_bits[nfall] = prev_out;
      nfall++;
    end
    if (!PGCx && !MCLRn) begin
      if (!seen_rise) pre_lo++;
      else post_lo++;
    end
    if (busy) busy_cyc++;
    if (rsp_valid) begin
      rsp_cnt++;
      rsp_word = rsp_data;
    end
    prev_pgc = PGCx; prev_out = PGDx_out; prev_dir = PGDx_dir;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] d, input bit hold);
    int n = 0;
    while (!cmd_ready && n < 2000) begin
      @(negedge clk50MHz);
      n++;
    end
    chk("ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    @(negedge clk50MHz);
    if (!hold) cmd_valid = 1'b0;
    chk("busy_rise", busy, 1);
  endtask

  task automatic run_monitor(input int poke_at);
    int cyc = 0;
    while (busy && cyc < 5000) begin
      observe();
      if (poke_at >= 0 && cyc == poke_at) begin
        cmd_valid = 1'b1; cmd_op = OP_SIX; cmd_data = $urandom;
      end else if (poke_at >= 0 && cyc == poke_at + 1) begin
        cmd_valid = 1'b0;
      end
      @(negedge clk50MHz);
      cyc++;
    end
    observe();
    chk("done_timeout", (cyc < 5000), 1);
  endtask

  task automatic check_cmd(input logic [1:0] op, input logic [31:0] d);
    logic [63:0] eb;
    int nb, er, eri, eb_busy;
    eb = '0; nb = 0; er = 0; eri = 0; eb_busy = 1;
    case (op)
      OP_SIX: begin
        for (int i = 0; i < SIX_W; i++) eb[4+i] = d[i];
        nb = 4 + SIX_W; er = nb;
        eb_busy = nb * 2 * CLK_DIV + 1;
      end
      OP_REGOUT: begin
        eb[0] = 1'b1; nb = 4;
        er = 4 + IDLE_CLKS + READ_W; eri = IDLE_CLKS + READ_W;
        eb_busy = er * 2 * CLK_DIV - CLK_DIV + 1;
        model_rsp = dev_word;
      end
      OP_ENTER: begin
        for (int i = 0; i < KEY_W; i++) eb[i] = d[KEY_W-1-i];
        nb = KEY_W; er = nb;
        eb_busy = 2 * MCLR_WAIT + KEY_W * 2 * CLK_DIV + 1;
        model_mclrn = 1'b1;
      end
      default: model_mclrn = 1'b0;
    endcase
    $display("op=%0d data=%08h rises=%0d busy=%0d rsp=%04h", op, d, rises, busy_cyc, rsp_data);
    chk("out_bits", obs_bits, eb);
    chk("out_nbits", nfall, nb);
    chk("pgc_rises", rises, er);
    chk("pgc_rises_dir_in", rises_in, eri);
    chk("busy_cycles", busy_cyc, eb_busy);
    chk("rsp_pulses", rsp_cnt, (op == OP_REGOUT) ? 1 : 0);
    if (op == OP_REGOUT) chk("rsp_word", rsp_word, dev_word);
    chk("rsp_data_held", rsp_data, model_rsp);
    chk("mclrn_after", MCLRn, model_mclrn);
    chk("idle_pins", {PGCx, PGDx_out, PGDx_dir, cmd_ready}, 4'b0011);
    if (op == OP_ENTER) begin
      chk("mclr_pre_low", pre_lo, MCLR_WAIT);
      chk("mclr_post_low", post_lo, MCLR_WAIT + CLK_DIV);
    end
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [31:0] d, input int poke_at);
    clear_stats();
    issue(op, d, 1'b0);
    run_monitor(poke_at);
    check_cmd(op, d);
  endtask

  initial begin
    int n;
    logic [1:0] rop;
    rstn = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; PGDx_in = 1'b0;
    dev_word = '0; model_rsp = '0; model_mclrn = 1'b0;
    repeat (3) @(negedge clk50MHz);
    chk("reset_pins", {PGCx, PGDx_out, PGDx_dir, MCLRn}, 4'b0010);
    chk("reset_hs", {cmd_ready, busy, rsp_valid}, 3'b000);
    chk("reset_rsp_data", rsp_data, 0);
    rstn = 1'b1;
    @(negedge clk50MHz);
    chk("ready_after_reset", cmd_ready, 1);

    // Directed: entry key, a SIX, a REGOUT
    do_cmd(OP_ENTER, ICSP_KEY, -1);
    do_cmd(OP_SIX, 32'h0004_0200, -1);
    dev_word = 16'hA55A;
    do_cmd(OP_REGOUT, 32'h0, -1);

    // SIX immediately followed by REGOUT with cmd_valid held high
    dev_word = 16'h3C96;
    clear_stats();
    issue(OP_SIX, 32'h00AB_CDEF, 1'b1);
    cmd_op = OP_REGOUT; cmd_data = '0;
    run_monitor(-1);
    check_cmd(OP_SIX, 32'h00AB_CDEF);
    chk("b2b_gap_pgc", PGCx, 0);
    chk("b2b_gap_ready", cmd_ready, 1);
    clear_stats();
    @(negedge clk50MHz);
    cmd_valid = 1'b0;
    chk("b2b_accept", busy, 1);
    run_monitor(-1);
    check_cmd(OP_REGOUT, 32'h0);

    // cmd_valid pulsed while busy must be dropped
    do_cmd(OP_SIX, 32'h0012_3456, 20);
    clear_stats();
    repeat (30) begin
      @(negedge clk50MHz);
      observe();
    end
    chk("ignored_busy", busy_cyc, 0);
    chk("ignored_rises", rises, 0);

    // Random command mix
    for (int t = 0; t < 12; t++) begin
      rop = 2'($urandom_range(0, 3));
      dev_word = 16'($urandom);
      do_cmd(rop, $urandom, -1);
    end

    // Reset in the middle of a REGOUT read phase
    do_cmd(OP_ENTER, $urandom, -1);
    dev_word = 16'($urandom);
    clear_stats();
    issue(OP_REGOUT, 32'h0, 1'b0);
    observe();
    n = 0;
    while (rises_in < IDLE_CLKS + 11 && n < 2000) begin
      @(negedge clk50MHz);
      observe();
      n++;
    end
    chk("reach_read_bit10", rises_in, IDLE_CLKS + 11);
    rstn = 1'b0;
    #1;
    chk("midrst_pins", {PGCx, PGDx_out, PGDx_dir, MCLRn}, 4'b0010);
    chk("midrst_hs", {cmd_ready, busy, rsp_valid}, 3'b000);
    model_rsp = '0; model_mclrn = 1'b0;
    rsp_cnt = 0;
    repeat (3) begin
      @(negedge clk50MHz);
      if (rsp_valid) rsp_cnt++;
    end
    chk("midrst_no_rsp", rsp_cnt, 0);
    chk("midrst_rsp_data", rsp_data, 0);
    rstn = 1'b1;
    PGDx_in = 1'b0;
    @(negedge clk50MHz);
    do_cmd(OP_SIX, $urandom, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
